// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues data-memory loads/stores over a req/ready + rvalid
// handshake, formats load data and stalls upstream while an access is in flight.
module mem_access_stage #(
    parameter int MAX_WAIT = 255,
    parameter int TW       = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] rs2_data_in,
    input  logic [4:0]  rd_in,
    input  logic        RegWrite_in,
    input  logic        MemToReg_in,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic [2:0]  funct3_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_ready,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] mem_data_out,
    output logic [31:0] alu_result_out,
    output logic [4:0]  rd_out,
    output logic        RegWrite_out,
    output logic        MemToReg_out,
    output logic        stall_out,
    output logic        misaligned_out,
    output logic        timeout_out
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP} state_t;

    state_t         state_p0, state_nxt;
    logic [TW-1:0]  cnt_p0, cnt_nxt;
    logic [31:0]    addr_p0, data_p0;
    logic [4:0]     rd_p0;
    logic           regwrite_p0, memtoreg_p0, we_p0;
    logic [2:0]     f3_p0;
    logic           latch_en;

    logic [31:0]    src_addr, src_data;
    logic [2:0]     src_f3;
    logic           is_mem_in;

    // funct3[1:0]: 00 byte, 01 halfword, anything else a full word.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   return 1'b0;
            2'b01:   return off[0];
            default: return off != 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << {off[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] load_align(input logic [31:0] word, input logic [2:0] f3,
                                               input logic [1:0] off);
        logic        [31:0] lane;
        logic signed [7:0]  b_s;
        logic signed [15:0] h_s;
        lane = word >> {off, 3'b000};
        b_s  = lane[7:0];
        h_s  = lane[15:0];
        case (f3)
            3'b000:  return 32'(b_s);
            3'b001:  return 32'(h_s);
            3'b100:  return {24'd0, lane[7:0]};
            3'b101:  return {16'd0, lane[15:0]};
            default: return word;
        endcase
    endfunction

    assign is_mem_in = MemRead_in | MemWrite_in;
    assign src_addr  = (state_p0 == IDLE) ? alu_result_in : addr_p0;
    assign src_data  = (state_p0 == IDLE) ? rs2_data_in   : data_p0;
    assign src_f3    = (state_p0 == IDLE) ? funct3_in     : f3_p0;

    always_comb begin
        state_nxt      = state_p0;
        cnt_nxt        = cnt_p0;
        latch_en       = 1'b0;
        dmem_req       = 1'b0;
        dmem_we        = 1'b0;
        dmem_addr      = 32'd0;
        dmem_wdata     = 32'd0;
        dmem_wstrb     = 4'd0;
        mem_data_out   = 32'd0;
        alu_result_out = 32'd0;
        rd_out         = 5'd0;
        RegWrite_out   = 1'b0;
        MemToReg_out   = 1'b0;
        stall_out      = 1'b0;
        misaligned_out = 1'b0;
        timeout_out    = 1'b0;
        case (state_p0)
            IDLE: begin
                if (valid_in) begin
                    alu_result_out = alu_result_in;
                    rd_out         = rd_in;
                    RegWrite_out   = RegWrite_in;
                    MemToReg_out   = MemToReg_in;
                    if (is_mem_in) begin
                        if (is_misaligned(funct3_in, alu_result_in[1:0])) begin
                            misaligned_out = 1'b1;
                            RegWrite_out   = 1'b0;
                        end else begin
                            latch_en   = 1'b1;
                            cnt_nxt    = '0;
                            dmem_req   = 1'b1;
                            dmem_we    = MemWrite_in;
                            dmem_addr  = {src_addr[31:2], 2'b00};
                            dmem_wdata = store_data(src_f3, src_data);
                            dmem_wstrb = MemWrite_in ? store_strb(src_f3, src_addr[1:0]) : 4'd0;
                            // An accepted store retires now; everything else must wait.
                            if (!(MemWrite_in && dmem_ready)) begin
                                stall_out    = 1'b1;
                                RegWrite_out = 1'b0;
                                rd_out       = 5'd0;
                                state_nxt    = dmem_ready ? WAIT_RESP : REQ;
                            end
                        end
                    end
                end
            end
            REQ: begin
                dmem_req       = 1'b1;
                dmem_we        = we_p0;
                dmem_addr      = {src_addr[31:2], 2'b00};
                dmem_wdata     = store_data(src_f3, src_data);
                dmem_wstrb     = we_p0 ? store_strb(src_f3, src_addr[1:0]) : 4'd0;
                alu_result_out = addr_p0;
                MemToReg_out   = memtoreg_p0;
                cnt_nxt        = '0;
                if (dmem_ready && we_p0) begin
                    rd_out       = rd_p0;
                    RegWrite_out = regwrite_p0;
                    state_nxt    = IDLE;
                end else begin
                    stall_out = 1'b1;
                    if (dmem_ready) state_nxt = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                alu_result_out = addr_p0;
                MemToReg_out   = memtoreg_p0;
                if (dmem_rvalid) begin
                    mem_data_out = load_align(dmem_rdata, f3_p0, addr_p0[1:0]);
                    rd_out       = rd_p0;
                    RegWrite_out = regwrite_p0;
                    cnt_nxt      = '0;
                    state_nxt    = IDLE;
                end else if (cnt_p0 == TW'(MAX_WAIT)) begin
                    timeout_out = 1'b1;
                    cnt_nxt     = '0;
                    state_nxt   = IDLE;
                end else begin
                    stall_out = 1'b1;
                    cnt_nxt   = cnt_p0 + TW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture stage: holds the access stable while it is outstanding.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_p0    <= IDLE;
            cnt_p0      <= '0;
            addr_p0     <= 32'd0;
            data_p0     <= 32'd0;
            rd_p0       <= 5'd0;
            regwrite_p0 <= 1'b0;
            memtoreg_p0 <= 1'b0;
            we_p0       <= 1'b0;
            f3_p0       <= 3'd0;
        end else begin
            state_p0 <= state_nxt;
            cnt_p0   <= cnt_nxt;
            if (latch_en) begin
                addr_p0     <= alu_result_in;
                data_p0     <= rs2_data_in;
                rd_p0       <= rd_in;
                regwrite_p0 <= RegWrite_in;
                memtoreg_p0 <= MemToReg_in;
                we_p0       <= MemWrite_in;
                f3_p0       <= funct3_in;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: pass-through, stores, loads, stalls,
// misalignment, response timeout and reset during an outstanding load.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic [31:0] alu_result_in, rs2_data_in, dmem_rdata;
    logic [4:0]  rd_in;
    logic        RegWrite_in, MemToReg_in, MemRead_in, MemWrite_in;
    logic [2:0]  funct3_in;
    logic        dmem_ready, dmem_rvalid;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, mem_data_out, alu_result_out;
    logic [3:0]  dmem_wstrb;
    logic [4:0]  rd_out;
    logic        RegWrite_out, MemToReg_out, stall_out, misaligned_out, timeout_out;

    int total = 0;
    int bad   = 0;

    mem_access_stage dut (
        .clk(clk), .reset(reset), .valid_in(valid_in),
        .alu_result_in(alu_result_in), .rs2_data_in(rs2_data_in), .rd_in(rd_in),
        .RegWrite_in(RegWrite_in), .MemToReg_in(MemToReg_in),
        .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in), .funct3_in(funct3_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_ready(dmem_ready),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .mem_data_out(mem_data_out), .alu_result_out(alu_result_out), .rd_out(rd_out),
        .RegWrite_out(RegWrite_out), .MemToReg_out(MemToReg_out), .stall_out(stall_out),
        .misaligned_out(misaligned_out), .timeout_out(timeout_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        valid_in = 0; alu_result_in = 0; rs2_data_in = 0; rd_in = 0;
        RegWrite_in = 0; MemToReg_in = 0; MemRead_in = 0; MemWrite_in = 0;
        funct3_in = 0; dmem_ready = 0; dmem_rvalid = 0; dmem_rdata = 0;
    endtask

    task automatic set_op(input logic [31:0] addr, input logic [31:0] data, input logic [4:0] rd,
                          input logic rw, input logic m2r, input logic mr, input logic mw,
                          input logic [2:0] f3);
        valid_in = 1; alu_result_in = addr; rs2_data_in = data; rd_in = rd;
        RegWrite_in = rw; MemToReg_in = m2r; MemRead_in = mr; MemWrite_in = mw; funct3_in = f3;
    endtask

    initial begin
        int  n;
        bit  seen;
        clear_inputs();
        reset = 0;
        #1;
        chk("rst_req", dmem_req, 0);
        chk("rst_stall", stall_out, 0);
        chk("rst_alu", alu_result_out, 0);
        chk("rst_rw", RegWrite_out, 0);
        tick(); tick();
        reset = 1;

        // Non-memory op: same-cycle pass-through.
        set_op(32'h1234, 0, 5, 1, 0, 0, 0, 3'b010);
        #1;
        chk("nm_alu", alu_result_out, 32'h1234);
        chk("nm_rd", rd_out, 5);
        chk("nm_rw", RegWrite_out, 1);
        chk("nm_req", dmem_req, 0);
        chk("nm_stall", stall_out, 0);
        chk("nm_data", mem_data_out, 0);
        tick();

        // SB at byte lane 3, accepted immediately.
        set_op(32'h1003, 32'h0000_00AB, 0, 0, 0, 0, 1, 3'b000);
        dmem_ready = 1;
        #1;
        chk("sb_req", dmem_req, 1);
        chk("sb_we", dmem_we, 1);
        chk("sb_addr", dmem_addr, 32'h1000);
        chk("sb_wdata", dmem_wdata, 32'hABABABAB);
        chk("sb_wstrb", dmem_wstrb, 4'b1000);
        chk("sb_stall", stall_out, 0);
        tick();

        // SH at upper halfword.
        set_op(32'h1002, 32'h1234_CDEF, 0, 0, 0, 0, 1, 3'b001);
        #1;
        chk("sh_wdata", dmem_wdata, 32'hCDEFCDEF);
        chk("sh_wstrb", dmem_wstrb, 4'b1100);
        chk("sh_stall", stall_out, 0);
        tick();

        // LB at 0x2001, response two cycles after acceptance.
        set_op(32'h2001, 0, 7, 1, 1, 1, 0, 3'b000);
        dmem_ready = 1;
        #1;
        chk("lb_req", dmem_req, 1);
        chk("lb_we", dmem_we, 0);
        chk("lb_addr", dmem_addr, 32'h2000);
        chk("lb_stall0", stall_out, 1);
        chk("lb_rw0", RegWrite_out, 0);
        tick();
        dmem_ready = 0;
        #1;
        chk("lb_stall1", stall_out, 1);
        chk("lb_req1", dmem_req, 0);
        chk("lb_rd1", rd_out, 0);
        tick();
        dmem_rvalid = 1; dmem_rdata = 32'h0000_8000;
        #1;
        chk("lb_data", mem_data_out, 32'hFFFFFF80);
        chk("lb_stall2", stall_out, 0);
        chk("lb_rd", rd_out, 7);
        chk("lb_rw", RegWrite_out, 1);
        tick();
        clear_inputs();

        // LHU at 0x2002 with ready low for three cycles.
        set_op(32'h2002, 0, 9, 1, 1, 1, 0, 3'b101);
        #1;
        chk("lhu_req0", dmem_req, 1);
        chk("lhu_stall0", stall_out, 1);
        tick();
        alu_result_in = 32'h5555; funct3_in = 3'b010;
        dmem_rvalid = 1; dmem_rdata = 32'hDEADDEAD;
        #1;
        chk("lhu_req1", dmem_req, 1);
        chk("lhu_addr1", dmem_addr, 32'h2000);
        chk("lhu_rvig", RegWrite_out, 0);
        chk("lhu_stall1", stall_out, 1);
        tick();
        dmem_rvalid = 0;
        #1;
        chk("lhu_req2", dmem_req, 1);
        tick();
        dmem_ready = 1;
        #1;
        chk("lhu_req3", dmem_req, 1);
        chk("lhu_addr3", dmem_addr, 32'h2000);
        chk("lhu_stall3", stall_out, 1);
        tick();
        dmem_ready = 0; dmem_rvalid = 1; dmem_rdata = 32'hBEEF0000;
        #1;
        chk("lhu_data", mem_data_out, 32'h0000BEEF);
        chk("lhu_rd", rd_out, 9);
        chk("lhu_alu", alu_result_out, 32'h2002);
        chk("lhu_stall4", stall_out, 0);
        tick();
        clear_inputs();

        // Misaligned LW and SH.
        set_op(32'h3002, 0, 3, 1, 1, 1, 0, 3'b010);
        dmem_ready = 1;
        #1;
        chk("mlw_mis", misaligned_out, 1);
        chk("mlw_req", dmem_req, 0);
        chk("mlw_rw", RegWrite_out, 0);
        chk("mlw_stall", stall_out, 0);
        tick();
        set_op(32'h3001, 32'h55, 0, 0, 0, 0, 1, 3'b001);
        #1;
        chk("msh_mis", misaligned_out, 1);
        chk("msh_req", dmem_req, 0);
        chk("msh_stall", stall_out, 0);
        tick();
        clear_inputs();
        #1;
        chk("mis_clear", misaligned_out, 0);

        // Load accepted, no response: timeout after MAX_WAIT counted cycles.
        set_op(32'h4000, 0, 4, 1, 1, 1, 0, 3'b010);
        dmem_ready = 1;
        tick();
        dmem_ready = 0;
        n = 0; seen = 0;
        while (n < 300 && !seen) begin
            #1;
            if (timeout_out) seen = 1;
            else begin
                n++;
                tick();
            end
        end
        chk("to_seen", {31'd0, seen}, 1);
        chk("to_cycles", n, 255);
        chk("to_stall", stall_out, 0);
        chk("to_rw", RegWrite_out, 0);
        tick();
        clear_inputs();
        #1;
        chk("to_pulse", timeout_out, 0);
        chk("to_idle_stall", stall_out, 0);
        tick();

        // Reset while waiting for a load response.
        set_op(32'h5000, 0, 6, 1, 1, 1, 0, 3'b010);
        dmem_ready = 1;
        tick();
        dmem_ready = 0;
        tick();
        #2;
        reset = 0;
        clear_inputs();
        #1;
        chk("mr_req", dmem_req, 0);
        chk("mr_stall", stall_out, 0);
        chk("mr_alu", alu_result_out, 0);
        chk("mr_rd", rd_out, 0);
        tick();
        reset = 1;
        dmem_rvalid = 1; dmem_rdata = 32'h12345678;
        #1;
        chk("mr_late_data", mem_data_out, 0);
        chk("mr_late_rw", RegWrite_out, 0);
        chk("mr_late_stall", stall_out, 0);
        tick();
        clear_inputs();

        // Fresh word load after the abandoned one.
        set_op(32'h6004, 0, 8, 1, 1, 1, 0, 3'b010);
        dmem_ready = 1;
        #1;
        chk("lw_addr", dmem_addr, 32'h6004);
        tick();
        dmem_ready = 0; dmem_rvalid = 1; dmem_rdata = 32'hCAFEF00D;
        #1;
        chk("lw_data", mem_data_out, 32'hCAFEF00D);
        chk("lw_rd", rd_out, 8);
        tick();
        clear_inputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
